// File: rtl/bpu_btb_pkg.sv
// Shared BPU constants: jump-op class encoding used by both the BTB and the RAS,
// plus the zero word used to clear address-wide outputs.
package bpu_btb_pkg;

  localparam logic [2:0] BTB_NONEOP        = 3'b000;
  localparam logic [2:0] BTB_BRANCHOP      = 3'b001;
  localparam logic [2:0] BTB_JUMPOP        = 3'b010;
  localparam logic [2:0] BTB_CALLOP        = 3'b011;
  localparam logic [2:0] BTB_RETOP         = 3'b100;
  localparam logic [2:0] BTB_CALLANDRETOP  = 3'b101;

  localparam logic [63:0] ZeroWord = 64'h0;

endpackage

// File: rtl/bpu_btb_way.sv
// One way of the BTB: flop-based storage for valid/tag/target/jumpop per set.
// Lookup read port, update probe port (valid+tag only), and one write/invalidate port.
module bpu_btb_way
  import bpu_btb_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int TAG_W = 12,
  parameter int XLEN  = 64,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [XLEN-1:0]  rd_target,
  output logic [2:0]       rd_jumpop,
  input  logic [IDX_W-1:0] pr_idx,
  output logic             pr_valid,
  output logic [TAG_W-1:0] pr_tag,
  input  logic             wr_en,
  input  logic             wr_inv,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [2:0]       wr_jumpop
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q    [SETS];
  logic [XLEN-1:0]  target_q [SETS];
  logic [2:0]       jumpop_q [SETS];

  // Only the valid bits need a reset; payload is ignored while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= !wr_inv;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wr_inv) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      jumpop_q[wr_idx] <= wr_jumpop;
    end
  end

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_jumpop = jumpop_q[rd_idx];
  assign pr_valid  = valid_q[pr_idx];
  assign pr_tag    = tag_q[pr_idx];

endmodule

// File: rtl/bpu_btb.sv
// 2-way set-associative branch target buffer with a registered lookup stage.
// Hit, jump-op class and pc+4 feed the return-address stack.
module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int TAG_W = 12,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_i,
  output logic            btb_hit_o,
  output logic [XLEN-1:0] btb_target_o,
  output logic [2:0]      btb_jumpop_o,
  output logic [XLEN-1:0] btb_retaddr_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic [2:0]      upd_jumpop_i
);

  localparam int IDX_W = $clog2(SETS);

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;

  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[TAG_W+IDX_W+1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[TAG_W+IDX_W+1:IDX_W+2];

  logic unused_upd_pc;
  assign unused_upd_pc = ^{upd_pc_i[XLEN-1:TAG_W+IDX_W+2], upd_pc_i[1:0]};

  logic             rd_valid  [2];
  logic [TAG_W-1:0] rd_tag    [2];
  logic [XLEN-1:0]  rd_target [2];
  logic [2:0]       rd_jumpop [2];
  logic             pr_valid  [2];
  logic [TAG_W-1:0] pr_tag    [2];
  logic             wr_en     [2];

  logic upd_inv;
  assign upd_inv = (upd_jumpop_i == BTB_NONEOP);

  for (genvar w = 0; w < 2; w++) begin : g_way
    bpu_btb_way #(
      .SETS (SETS),
      .TAG_W(TAG_W),
      .XLEN (XLEN)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (lk_idx),
      .rd_valid (rd_valid[w]),
      .rd_tag   (rd_tag[w]),
      .rd_target(rd_target[w]),
      .rd_jumpop(rd_jumpop[w]),
      .pr_idx   (up_idx),
      .pr_valid (pr_valid[w]),
      .pr_tag   (pr_tag[w]),
      .wr_en    (wr_en[w]),
      .wr_inv   (upd_inv),
      .wr_idx   (up_idx),
      .wr_tag   (up_tag),
      .wr_target(upd_target_i),
      .wr_jumpop(upd_jumpop_i)
    );
  end

  logic [SETS-1:0] lru_q;

  logic lk_hit0, lk_hit1, lk_hit, lk_way;
  assign lk_hit0 = rd_valid[0] && (rd_tag[0] == lk_tag);
  assign lk_hit1 = rd_valid[1] && (rd_tag[1] == lk_tag);
  assign lk_hit  = lk_hit0 || lk_hit1;
  assign lk_way  = !lk_hit0;

  logic up_m0, up_m1, alloc_way;
  assign up_m0 = pr_valid[0] && (pr_tag[0] == up_tag);
  assign up_m1 = pr_valid[1] && (pr_tag[1] == up_tag);

  always_comb begin
    alloc_way = lru_q[up_idx];
    if (up_m0)             alloc_way = 1'b0;
    else if (up_m1)        alloc_way = 1'b1;
    else if (!pr_valid[0]) alloc_way = 1'b0;
    else if (!pr_valid[1]) alloc_way = 1'b1;
  end

  // An invalidate clears every way holding the tag so no stale twin survives.
  always_comb begin
    wr_en[0] = 1'b0;
    wr_en[1] = 1'b0;
    if (upd_valid_i) begin
      if (upd_inv) begin
        wr_en[0] = up_m0;
        wr_en[1] = up_m1;
      end else begin
        wr_en[0] = !alloc_way;
        wr_en[1] = alloc_way;
      end
    end
  end

  // The update's LRU write comes last so it overrides a same-set lookup touch.
  always_ff @(posedge clk) begin
    if (rst) begin
      lru_q <= '0;
    end else begin
      if (!stall && !flush && lk_hit) lru_q[lk_idx] <= !lk_way;
      if (upd_valid_i && !upd_inv)    lru_q[up_idx] <= !alloc_way;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      btb_hit_o     <= 1'b0;
      btb_target_o  <= ZeroWord[XLEN-1:0];
      btb_jumpop_o  <= BTB_NONEOP;
      btb_retaddr_o <= ZeroWord[XLEN-1:0];
    end else if (!stall) begin
      btb_hit_o     <= lk_hit;
      btb_target_o  <= !lk_hit ? ZeroWord[XLEN-1:0] : (lk_hit0 ? rd_target[0] : rd_target[1]);
      btb_jumpop_o  <= !lk_hit ? BTB_NONEOP : (lk_hit0 ? rd_jumpop[0] : rd_jumpop[1]);
      btb_retaddr_o <= pc_i + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Directed bench for bpu_btb: reset, fill/hit, eviction, invalidate,
// stall/flush, same-set collision and pc+4 wrap.
module tb_bpu_btb;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst, stall, flush;
  logic [XLEN-1:0] pc_i;
  logic            btb_hit_o;
  logic [XLEN-1:0] btb_target_o;
  logic [2:0]      btb_jumpop_o;
  logic [XLEN-1:0] btb_retaddr_o;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i, upd_target_i;
  logic [2:0]      upd_jumpop_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bpu_btb #(.SETS(16), .TAG_W(12), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .pc_i         (pc_i),
    .btb_hit_o    (btb_hit_o),
    .btb_target_o (btb_target_o),
    .btb_jumpop_o (btb_jumpop_o),
    .btb_retaddr_o(btb_retaddr_o),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .upd_jumpop_i (upd_jumpop_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Update while the lookup port points at an unrelated set (set 3).
  task automatic do_update(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                           input logic [2:0] op);
    pc_i         = 64'h0000_0000_9000_000C;
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_target_i = tgt;
    upd_jumpop_i = op;
    step();
    upd_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_i = 64'h8000_0010;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_target_i = '0; upd_jumpop_i = 3'b000;
    step(); step();
    n_cmp += 4;
    if (btb_hit_o !== 1'b0) begin n_err++; $display("FAIL reset_hit got %0b want 0", btb_hit_o); end
    if (btb_target_o !== 64'h0) begin n_err++; $display("FAIL reset_target got %h want 0", btb_target_o); end
    if (btb_jumpop_o !== 3'b000) begin n_err++; $display("FAIL reset_jumpop got %0d want 0", btb_jumpop_o); end
    if (btb_retaddr_o !== 64'h0) begin n_err++; $display("FAIL reset_retaddr got %h want 0", btb_retaddr_o); end
    rst = 1'b0;
  endtask

  // Table-driven lookups: pc, expected hit/target/jumpop; retaddr is pc+4.
  task automatic test_lookups(input string name, input logic [XLEN-1:0] pcs[],
                              input logic hits[], input logic [XLEN-1:0] tgts[],
                              input logic [2:0] ops[]);
    for (int i = 0; i < pcs.size(); i++) begin
      pc_i = pcs[i];
      step();
      n_cmp += 4;
      if (btb_hit_o !== hits[i]) begin n_err++;
        $display("FAIL %s[%0d]_hit got %0b want %0b", name, i, btb_hit_o, hits[i]); end
      if (btb_target_o !== tgts[i]) begin n_err++;
        $display("FAIL %s[%0d]_target got %h want %h", name, i, btb_target_o, tgts[i]); end
      if (btb_jumpop_o !== ops[i]) begin n_err++;
        $display("FAIL %s[%0d]_jumpop got %0d want %0d", name, i, btb_jumpop_o, ops[i]); end
      if (btb_retaddr_o !== pcs[i] + 64'd4) begin n_err++;
        $display("FAIL %s[%0d]_retaddr got %h want %h", name, i, btb_retaddr_o, pcs[i] + 64'd4); end
    end
  endtask

  task automatic test_miss();
    test_lookups("miss", '{64'h8000_0010}, '{1'b0}, '{64'h0}, '{3'b000});
  endtask

  task automatic test_call_hit();
    do_update(64'h8000_0010, 64'h8000_0100, 3'b011);
    test_lookups("call_hit", '{64'h8000_0010}, '{1'b1}, '{64'h8000_0100}, '{3'b011});
  endtask

  task automatic test_invalidate_absent();
    // set 4, tag 1: nothing stored there
    do_update(64'h8000_0050, 64'h0, 3'b000);
    test_lookups("inv_absent", '{64'h8000_0010}, '{1'b1}, '{64'h8000_0100}, '{3'b011});
  endtask

  task automatic test_eviction();
    do_update(64'h8000_0000, 64'h8000_1000, 3'b010);
    do_update(64'h8000_0040, 64'h8000_2000, 3'b010);
    test_lookups("evict_pre", '{64'h8000_0000}, '{1'b1}, '{64'h8000_1000}, '{3'b010});
    do_update(64'h8000_0080, 64'h8000_3000, 3'b010);
    test_lookups("evict_post", '{64'h8000_0000, 64'h8000_0080, 64'h8000_0040},
                 '{1'b1, 1'b1, 1'b0}, '{64'h8000_1000, 64'h8000_3000, 64'h0},
                 '{3'b010, 3'b010, 3'b000});
  endtask

  task automatic test_stall_flush();
    logic [XLEN-1:0] stall_pcs [3];
    stall_pcs = '{64'h8000_0040, 64'h1234_5678, 64'h8000_0080};
    test_lookups("pre_stall", '{64'h8000_0000}, '{1'b1}, '{64'h8000_1000}, '{3'b010});
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_i = stall_pcs[i];
      step();
      n_cmp += 4;
      if (btb_hit_o !== 1'b1) begin n_err++; $display("FAIL stall[%0d]_hit got %0b want 1", i, btb_hit_o); end
      if (btb_target_o !== 64'h8000_1000) begin n_err++;
        $display("FAIL stall[%0d]_target got %h want 80001000", i, btb_target_o); end
      if (btb_jumpop_o !== 3'b010) begin n_err++;
        $display("FAIL stall[%0d]_jumpop got %0d want 2", i, btb_jumpop_o); end
      if (btb_retaddr_o !== 64'h8000_0004) begin n_err++;
        $display("FAIL stall[%0d]_retaddr got %h want 80000004", i, btb_retaddr_o); end
    end
    flush = 1'b1;
    pc_i  = 64'h8000_0000;
    step();
    n_cmp += 4;
    if (btb_hit_o !== 1'b0) begin n_err++; $display("FAIL flush_hit got %0b want 0", btb_hit_o); end
    if (btb_target_o !== 64'h0) begin n_err++; $display("FAIL flush_target got %h want 0", btb_target_o); end
    if (btb_jumpop_o !== 3'b000) begin n_err++; $display("FAIL flush_jumpop got %0d want 0", btb_jumpop_o); end
    if (btb_retaddr_o !== 64'h0) begin n_err++; $display("FAIL flush_retaddr got %h want 0", btb_retaddr_o); end
    flush = 1'b0;
    stall = 1'b0;
    test_lookups("post_flush", '{64'h8000_0000}, '{1'b1}, '{64'h8000_1000}, '{3'b010});
  endtask

  task automatic test_invalidate();
    do_update(64'h8000_0010, 64'h0, 3'b000);
    test_lookups("invalidate", '{64'h8000_0010}, '{1'b0}, '{64'h0}, '{3'b000});
  endtask

  task automatic test_collision();
    do_update(64'h8000_0020, 64'h8000_0180, 3'b001);
    pc_i         = 64'h8000_0020;
    upd_valid_i  = 1'b1;
    upd_pc_i     = 64'h8000_0020;
    upd_target_i = 64'h8000_0200;
    upd_jumpop_i = 3'b001;
    step();
    upd_valid_i  = 1'b0;
    n_cmp += 2;
    if (btb_hit_o !== 1'b1) begin n_err++; $display("FAIL collide_hit got %0b want 1", btb_hit_o); end
    if (btb_target_o !== 64'h8000_0180) begin n_err++;
      $display("FAIL collide_target got %h want 80000180 (old)", btb_target_o); end
    test_lookups("collide_next", '{64'h8000_0020}, '{1'b1}, '{64'h8000_0200}, '{3'b001});
  endtask

  task automatic test_back_to_back_wrap();
    test_lookups("b2b", '{64'h8000_0080, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8000_0000},
                 '{1'b1, 1'b0, 1'b1}, '{64'h8000_3000, 64'h0, 64'h8000_1000},
                 '{3'b010, 3'b000, 3'b010});
  endtask

  initial begin
    test_reset();
    test_miss();
    test_call_hit();
    test_invalidate_absent();
    test_eviction();
    test_stall_flush();
    test_invalidate();
    test_collision();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
